// File: rtl/pwm_measure_sequencer_if.sv
// Result handshake between the PWM measurement sequencer and the display stage.
// The producer holds width/class stable while res_valid_o is high.
interface pwm_measure_sequencer_if #(
  parameter int CNT_W = 12
);
  logic [CNT_W-1:0] width_o;
  logic [1:0]       class_o;
  logic             res_valid_o;
  logic             res_ready_i;

  modport master (
    output width_o,
    output class_o,
    output res_valid_o,
    input  res_ready_i
  );

  modport slave (
    input  width_o,
    input  class_o,
    input  res_valid_o,
    output res_ready_i
  );
endinterface

// File: rtl/pwm_measure_sequencer.sv
// Arms on enable, times one high pulse of the synchronised PWM input, classifies it
// and hands one result per pulse downstream. Optional macro PWM_GLITCH_FILTER_EN.
module pwm_measure_sequencer #(
  parameter int MAX_COUNTER_VALUE  = 2000,
  parameter int HIGH_COUNTER_VALUE = 1900,
  parameter int LOW_COUNTER_VALUE  = 1100,
  parameter int CNT_W              = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     pwm_i,
  output logic                     busy_o,
  pwm_measure_sequencer_if.master  res
);

  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_COUNTER_VALUE);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(2 * MAX_COUNTER_VALUE);
  localparam logic [CNT_W-1:0] HIGH_C    = CNT_W'(HIGH_COUNTER_VALUE);
  localparam logic [CNT_W-1:0] LOW_C     = CNT_W'(LOW_COUNTER_VALUE);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_RISE,
    MEASURE,
    REPORT
  } state_e;

  typedef enum logic [1:0] {
    CLS_LOW   = 2'b00,
    CLS_MID   = 2'b01,
    CLS_HIGH  = 2'b10,
    CLS_FAULT = 2'b11
  } cls_e;

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] width_q, width_n;
  cls_e             class_q, class_n;

  logic sync1, sync2;
  logic pwm_s, pwm_d;
  logic rise, fall;

  // NOTE: every flop uses <= so all registers update from pre-edge values, which is
  // what makes the two-flop synchroniser a real two-cycle pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pwm_i;
      sync2 <= sync1;
    end
  end

`ifdef PWM_GLITCH_FILTER_EN
  logic sync3;

  // Accept a new level only once three consecutive samples agree on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync3 <= 1'b0;
      pwm_s <= 1'b0;
    end else begin
      sync3 <= sync2;
      if ((sync1 == sync2) && (sync2 == sync3)) begin
        pwm_s <= sync3;
      end
    end
  end
`else
  assign pwm_s = sync2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_d <= 1'b0;
    end else begin
      pwm_d <= pwm_s;
    end
  end

  assign rise = pwm_s & ~pwm_d;
  assign fall = ~pwm_s & pwm_d;

  function automatic cls_e classify(input logic [CNT_W-1:0] w);
    if (w < LOW_C) begin
      return CLS_LOW;
    end else if (w > HIGH_C) begin
      return CLS_HIGH;
    end
    return CLS_MID;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      width_q <= '0;
      class_q <= CLS_LOW;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      width_q <= width_n;
      class_q <= class_n;
    end
  end

  // NOTE: every signal gets its hold value before the case so no path leaves one
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    width_n = width_q;
    class_n = class_q;

    unique case (state)
      IDLE: begin
        if (en_i) begin
          state_n = ARM;
          cnt_n   = '0;
        end
      end

      // A pulse already high when we arm is let through unmeasured.
      ARM: begin
        cnt_n = '0;
        if (!en_i) begin
          state_n = IDLE;
        end else if (!pwm_s) begin
          state_n = WAIT_RISE;
        end
      end

      WAIT_RISE: begin
        if (!en_i) begin
          state_n = IDLE;
        end else if (rise) begin
          cnt_n   = ONE_C;
          state_n = MEASURE;
        end else if (cnt >= TIMEOUT_C) begin
          width_n = '0;
          class_n = CLS_FAULT;
          state_n = REPORT;
        end else begin
          cnt_n = cnt + ONE_C;
        end
      end

      // Saturation wins over a simultaneous fall: a pulse reaching the limit is a fault.
      MEASURE: begin
        if (!en_i) begin
          state_n = IDLE;
        end else if (cnt >= MAX_C) begin
          width_n = MAX_C;
          class_n = CLS_FAULT;
          state_n = REPORT;
        end else if (fall) begin
          width_n = cnt;
          class_n = classify(cnt);
          state_n = REPORT;
        end else if (pwm_s) begin
          cnt_n = cnt + ONE_C;
        end
      end

      REPORT: begin
        if (res.res_ready_i) begin
          state_n = en_i ? ARM : IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign res.res_valid_o = (state == REPORT);
  assign res.width_o     = width_q;
  assign res.class_o     = class_q;
  assign busy_o          = (state != IDLE);

endmodule

// File: tb/tb_pwm_measure_sequencer.sv
// Self-checking bench: directed scenarios plus randomized pulses, with results
// predicted from the pulse widths the bench generates and checked every cycle.
`timescale 1ns/1ps
module tb_pwm_measure_sequencer;

  localparam int CNT_W  = 12;
  localparam int MAXV   = 2000;
  localparam int HIGHV  = 1900;
  localparam int LOWV   = 1100;
`ifdef PWM_GLITCH_FILTER_EN
  localparam int LAT    = 5;
`else
  localparam int LAT    = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic pwm;
  logic busy;

  pwm_measure_sequencer_if #(.CNT_W(CNT_W)) res_if ();

  pwm_measure_sequencer #(
    .MAX_COUNTER_VALUE (MAXV),
    .HIGH_COUNTER_VALUE(HIGHV),
    .LOW_COUNTER_VALUE (LOWV),
    .CNT_W             (CNT_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en_i  (en),
    .pwm_i (pwm),
    .busy_o(busy),
    .res   (res_if.master)
  );

  always #500 clk = ~clk;

  typedef struct {
    int width;
    int cls;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected result for a clean high pulse of n input cycles.
  function automatic exp_t model(input int n);
    exp_t e;
    if (n >= MAXV) begin
      e.width = MAXV;
      e.cls   = 3;
    end else begin
      e.width = n;
      e.cls   = (n < LOWV) ? 0 : (n > HIGHV) ? 2 : 1;
    end
    return e;
  endfunction

  function automatic exp_t lit(input int w, input int c);
    exp_t e;
    e.width = w;
    e.cls   = c;
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    pwm = 1'b1;
    tick(n);
    pwm = 1'b0;
  endtask

  task automatic wait_accept(input int budget, input bit rnd_ready);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      if (rnd_ready) res_if.res_ready_i = 1'($urandom_range(0, 1));
      tick(1);
      k++;
    end
    res_if.res_ready_i = 1'b1;
    check("result_delivered", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Result scoreboard: any valid cycle must carry the oldest predicted result.
  always @(negedge clk) begin
    if (!rst && res_if.res_valid_o) begin
      check("busy_in_report", int'(busy), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", int'(res_if.res_valid_o), 0);
      end else begin
        check("res_width", int'(res_if.width_o), exp_q[0].width);
        check("res_class", int'(res_if.class_o), exp_q[0].cls);
        if (res_if.res_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #(64'd90_000 * 64'd1000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int widths[4] = '{1099, 1100, 1900, 1901};
    int classes[4] = '{0, 1, 1, 2};
    exp_t e;

    rst = 1'b1;
    en  = 1'b0;
    pwm = 1'b0;
    res_if.res_ready_i = 1'b0;
    tick(5);
    check("rst_busy",  int'(busy), 0);
    check("rst_valid", int'(res_if.res_valid_o), 0);
    check("rst_width", int'(res_if.width_o), 0);
    check("rst_class", int'(res_if.class_o), 0);
    rst = 1'b0;
    tick(2);
    check("idle_busy", int'(busy), 0);

    // 1500-cycle pulse: MID, fixed latency, one valid cycle.
    en = 1'b1;
    res_if.res_ready_i = 1'b1;
    tick(10);
    check("armed_busy", int'(busy), 1);
    exp_q.push_back(lit(1500, 1));
    pulse(1500);
    lat = 0;
    do begin
      tick(1);
      lat++;
    end while (!res_if.res_valid_o && lat < 20);
    check("latency", lat, LAT);
    check("w1500_width", int'(res_if.width_o), 1500);
    tick(1);
    check("valid_one_cycle", int'(res_if.res_valid_o), 0);
    wait_accept(20, 1'b0);
    tick(10);

    // Threshold boundaries.
    for (int i = 0; i < 4; i++) begin
      e = model(widths[i]);
      check("model_pin_class", e.cls, classes[i]);
      exp_q.push_back(e);
      pulse(widths[i]);
      wait_accept(40, 1'b0);
      tick(10);
    end

    // Over-long pulse: saturating fault, then only a fresh pulse is measured.
    exp_q.push_back(lit(2000, 3));
    pulse(2500);
    wait_accept(10, 1'b0);
    tick(20);
    exp_q.push_back(model(300));
    pulse(300);
    wait_accept(40, 1'b0);

    // No rise at all: timeout fault with width 0.
    en = 1'b0;
    tick(3);
    check("drop_idle", int'(busy), 0);
    en = 1'b1;
    exp_q.push_back(lit(0, 3));
    lat = 0;
    do begin
      tick(1);
      lat++;
    end while (!res_if.res_valid_o && lat < 4100);
    check("timeout_window", int'(lat >= 4000 && lat <= 4010), 1);
    tick(4100 - lat);
    wait_accept(5, 1'b0);
    en = 1'b0;
    tick(3);

    // Consumer stall: result held, pulse during REPORT ignored.
    en = 1'b1;
    tick(10);
    res_if.res_ready_i = 1'b0;
    exp_q.push_back(lit(1200, 1));
    pulse(1200);
    lat = 0;
    do begin
      tick(1);
      lat++;
    end while (!res_if.res_valid_o && lat < 20);
    check("stall_valid_seen", int'(res_if.res_valid_o), 1);
    tick(5);
    pulse(20);
    tick(25);
    check("stall_valid_held", int'(res_if.res_valid_o), 1);
    check("stall_width", int'(res_if.width_o), 1200);
    check("stall_class", int'(res_if.class_o), 1);
    res_if.res_ready_i = 1'b1;
    tick(1);
    check("accept_valid_drop", int'(res_if.res_valid_o), 0);
    check("accept_to_arm", int'(busy), 1);
    check("stall_popped", exp_q.size(), 0);
    exp_q.delete();
    tick(10);
    exp_q.push_back(model(700));
    pulse(700);
    wait_accept(40, 1'b0);
    tick(10);

    // Enable drop mid-measurement: back to idle, no result.
    pwm = 1'b1;
    tick(503);
    en = 1'b0;
    tick(1);
    check("en_drop_busy", int'(busy), 0);
    tick(700);
    pwm = 1'b0;
    tick(10);
    check("en_drop_no_valid", int'(res_if.res_valid_o), 0);
    en = 1'b1;
    tick(10);

    // Reset while measuring: every output returns to zero.
    pwm = 1'b1;
    tick(300);
    rst = 1'b1;
    tick(1);
    check("mrst_busy",  int'(busy), 0);
    check("mrst_valid", int'(res_if.res_valid_o), 0);
    check("mrst_width", int'(res_if.width_o), 0);
    check("mrst_class", int'(res_if.class_o), 0);
    rst = 1'b0;
    pwm = 1'b0;
    tick(10);

    // Two-cycle glitch.
`ifdef PWM_GLITCH_FILTER_EN
    pulse(2);
    tick(50);
    check("glitch_no_valid", int'(res_if.res_valid_o), 0);
    check("glitch_busy", int'(busy), 1);
`else
    exp_q.push_back(model(2));
    pulse(2);
    wait_accept(40, 1'b0);
`endif
    tick(10);

    // Randomized pulses with a randomly stalling consumer.
    for (int i = 0; i < 12; i++) begin
      int n;
      n = int'($urandom_range(3, 2300));
      exp_q.push_back(model(n));
      pulse(n);
      wait_accept(300, 1'b1);
      tick(int'($urandom_range(5, 60)));
    end

    en = 1'b0;
    tick(5);
    check("final_idle", int'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_measure_sequencer.md
Name: pwm_measure_sequencer

Overview:
- Sequences the PWM-analyzer counter: arms on enable, times one high pulse of the PWM input, classifies it and hands one result per pulse to the display stage.
- Sits between the pad inputs (`ui_in[7]` enable, PWM pin) and the 7-segment decode logic.
- Owns all start, stop and clear decisions for the width counter; the display side only consumes results.

Parameters:
- `MAX_COUNTER_VALUE`, 2000: counter saturation value; a pulse reaching it is a fault.
- `HIGH_COUNTER_VALUE`, 1900: widths strictly above this classify HIGH.
- `LOW_COUNTER_VALUE`, 1100: widths strictly below this classify LOW.
- `CNT_W`, 12: counter/result width; must hold `2*MAX_COUNTER_VALUE`.

Ports:
- `clk`  in  1  system clock (1 MHz nominal).
- `rst`  in  1  synchronous reset, active-high.
- `en_i`  in  1  measurement enable (`ui_in[7]`); level, synchronous to `clk`.
- `pwm_i`  in  1  raw asynchronous PWM input.
- `width_o`  out  CNT_W  measured high time in `clk` cycles.
- `class_o`  out  2  00 LOW, 01 MID, 10 HIGH, 11 FAULT.
- `res_valid_o`  out  1  result valid.
- `res_ready_i`  in  1  consumer accepts result.
- `busy_o`  out  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - All outputs 0; state IDLE; counter 0.
  - Synchroniser flops cleared to 0.
- Synchroniser and edge detection:
  - `pwm_i` passes through 2 flops to give `pwm_s`.
  - Edges are detected on `pwm_s` against its registered copy.
- States: IDLE, ARM, WAIT_RISE, MEASURE, REPORT.
- IDLE: when `en_i`=1, go to ARM and clear the counter.
- ARM: wait for `pwm_s`=0, then go to WAIT_RISE. A pulse already in progress at arm time is never measured.
- WAIT_RISE:
  - Counter increments every cycle.
  - Rising edge of `pwm_s`: clear the counter to 1 and go to MEASURE. The first high cycle counts.
  - Counter reaches `2*MAX_COUNTER_VALUE` with no rise: load result width 0, class FAULT, go to REPORT.
- MEASURE:
  - Counter increments every cycle while `pwm_s`=1.
  - Falling edge of `pwm_s`: result width = counter (number of high samples), then go to REPORT.
  - Counter reaches `MAX_COUNTER_VALUE` while still high: width = `MAX_COUNTER_VALUE`, class FAULT, go to REPORT.
- Classification, applied only to non-fault results:
  - width < `LOW_COUNTER_VALUE` gives LOW.
  - width > `HIGH_COUNTER_VALUE` gives HIGH.
  - Otherwise MID; both thresholds are inclusive for MID.
- REPORT:
  - `res_valid_o`=1; `width_o`/`class_o` are registered and stable while valid.
  - `pwm_s` is ignored.
  - On `res_valid_o` && `res_ready_i`: `res_valid_o` drops the next cycle and the FSM goes to ARM.
- Latency:
  - `res_valid_o` rises 1 cycle after the cycle in which the falling edge is detected.
  - That is 3 cycles after the falling edge of `pwm_i`.
- Enable drop:
  - `en_i`=0 in any state except REPORT: go to IDLE next cycle, discard any partial measurement, no result produced.
  - `en_i`=0 in REPORT: the pending result stays valid until accepted, then go to IDLE.
- `res_ready_i` held high in REPORT: the handshake completes in the first valid cycle.
- `rst` mid-operation: immediate return to the reset values on the next edge; a pending result is lost.
- Counter arithmetic: unsigned, saturates at its terminal value and never wraps.

Optional Feature:
- Macro `PWM_GLITCH_FILTER_EN`.
- Defined:
  - A third stage follows the synchroniser.
  - `pwm_s` changes only after the synchronised input has held the new level for 3 consecutive cycles.
  - Pulses or gaps shorter than 3 cycles are ignored.
  - Widths are unchanged because both edges are delayed equally.
  - Result latency grows by 2 cycles, to 5 cycles after the `pwm_i` fall.
- Undefined: plain 2-flop synchroniser; every level change is accepted.

Test Plan:
- en=1, `res_ready_i`=1, `pwm_i` high for 1500 cycles → one result: width 1500, class 01, `res_valid_o` high for 1 cycle, 3 cycles after the fall.
- Pulses of 1099, 1100, 1900 and 1901 cycles → classes 00, 01, 01, 10 with exact widths.
- `pwm_i` held high for 2500 cycles after the rise → width 2000, class 11. The next measurement is taken only after `pwm_i` goes low and rises again.
- en=1 with `pwm_i`=0 for 4100 cycles → FAULT result with width 0 at cycle 4000 of WAIT_RISE.
- `res_ready_i`=0 for 50 cycles after a 1200-cycle pulse:
  - `res_valid_o` and the result (width 1200, class 01) stay stable.
  - A second pulse during REPORT is not measured.
  - After accept, the FSM returns to ARM.
- `en_i` dropped 500 cycles into MEASURE → `busy_o`=0 the next cycle and no `res_valid_o`.
- `rst` pulsed in MEASURE → all outputs 0.
- With `PWM_GLITCH_FILTER_EN`, a 2-cycle glitch produces no result.
